// File: rtl/axi4lite_dma_frame_ctrl.sv
// Register bank and frame-buffer sequencer for the video DMA write path.
// Issues one DMA command per frame, rotating across up to four buffers, and flags completion.
module axi4lite_dma_frame_ctrl #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        mem_wr_valid,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_addr,
  output logic [31:0] mem_rd_data,
  output logic        dma_start,
  output logic [31:0] dma_addr,
  output logic [31:0] dma_len,
  input  logic        dma_done,
  input  logic        dma_err,
  output logic        dma_abort,
  output logic        busy,
  output logic [1:0]  done_buf_idx,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_NEXT} state_e;

  localparam logic [23:0]      TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
  localparam logic [CNT_W-1:0] CNT_ONE      = 1;

  state_e            state_q, state_d;
  logic              run_q, run_d, irq_en_q, irq_en_d;
  logic [2:0]        num_buf_q, num_buf_d, pend_q, pend_d, pend_set, w1c;
  logic [31:0]       buf_addr_q [4];
  logic [31:0]       buf_addr_d [4];
  logic [31:0]       xfer_len_q, xfer_len_d, dma_addr_q, dma_addr_d, dma_len_q, dma_len_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]        cur_idx_q, cur_idx_d, done_idx_q, done_idx_d;
  logic [23:0]       timer_q, timer_d;
  logic              abort_q, abort_d, irq_q, irq_d;
  logic              cnt_clr, frame_done, timeout_hit;
  logic [2:0]        idx_inc;
  logic [5:0]        wr_off, rd_off;
  logic [31:0]       status;
  logic              unused_addr_bits;

  assign wr_off  = mem_wr_addr[7:2];
  assign rd_off  = mem_rd_addr[7:2];
  assign idx_inc = {1'b0, cur_idx_q} + 3'd1;
  assign unused_addr_bits = ^{mem_wr_addr[31:8], mem_wr_addr[1:0], mem_rd_addr[31:8], mem_rd_addr[1:0]};

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    run_d      = run_q;
    irq_en_d   = irq_en_q;
    num_buf_d  = num_buf_q;
    buf_addr_d = buf_addr_q;
    xfer_len_d = xfer_len_q;
    cnt_clr    = 1'b0;
    w1c        = '0;
    if (mem_wr_valid) begin
      case (wr_off)
        6'h00: begin
          run_d    = mem_wr_data[0];
          irq_en_d = mem_wr_data[1];
          cnt_clr  = mem_wr_data[2];
        end
        6'h02: w1c = mem_wr_data[2:0];
        6'h03: begin
          if (mem_wr_data[2:0] == 3'd0)     num_buf_d = 3'd1;
          else if (mem_wr_data[2:0] > 3'd4) num_buf_d = 3'd4;
          else                              num_buf_d = mem_wr_data[2:0];
        end
        6'h04, 6'h05, 6'h06, 6'h07: buf_addr_d[wr_off[1:0]] = mem_wr_data;
        6'h08: xfer_len_d = mem_wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    done_idx_d  = done_idx_q;
    timer_d     = timer_q;
    dma_addr_d  = dma_addr_q;
    dma_len_d   = dma_len_q;
    abort_d     = 1'b0;
    frame_done  = 1'b0;
    pend_set    = '0;
    timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (timer_q == TIMEOUT_LAST);
    case (state_q)
      S_IDLE:  if (run_q) state_d = S_START;
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 24'd1;
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (dma_done) begin
          done_idx_d  = cur_idx_q;
          frame_done  = 1'b1;
          pend_set[0] = 1'b1;
          pend_set[1] = dma_err;
          state_d     = S_NEXT;
        end else if (timeout_hit) begin
          abort_d     = 1'b1;
          pend_set[2] = 1'b1;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        cur_idx_d = (idx_inc >= num_buf_q) ? 2'd0 : idx_inc[1:0];
        state_d   = run_q ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Command fields are captured on entry so they are stable while dma_start is high.
    if (state_d == S_START) begin
      dma_addr_d = buf_addr_q[cur_idx_d];
      dma_len_d  = xfer_len_q;
    end
    frame_cnt_d = cnt_clr ? '0 : (frame_done ? frame_cnt_q + CNT_ONE : frame_cnt_q);
    pend_d      = (pend_q & ~w1c) | pend_set;
    irq_d       = irq_en_q & (|pend_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      num_buf_q   <= 3'd1;
      // NOTE: the buffer base addresses are plain flops, so they take the reset like every other register.
      buf_addr_q  <= '{default: '0};
      xfer_len_q  <= '0;
      pend_q      <= '0;
      frame_cnt_q <= '0;
      cur_idx_q   <= '0;
      done_idx_q  <= '0;
      timer_q     <= '0;
      dma_addr_q  <= '0;
      dma_len_q   <= '0;
      abort_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      irq_en_q    <= irq_en_d;
      num_buf_q   <= num_buf_d;
      buf_addr_q  <= buf_addr_d;
      xfer_len_q  <= xfer_len_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
      cur_idx_q   <= cur_idx_d;
      done_idx_q  <= done_idx_d;
      timer_q     <= timer_d;
      dma_addr_q  <= dma_addr_d;
      dma_len_q   <= dma_len_d;
      abort_q     <= abort_d;
      irq_q       <= irq_d;
    end
  end

  assign dma_start    = (state_q == S_START);
  assign busy         = (state_q != S_IDLE);
  assign dma_abort    = abort_q;
  assign irq          = irq_q;
  assign dma_addr     = dma_addr_q;
  assign dma_len      = dma_len_q;
  assign done_buf_idx = done_idx_q;

  always_comb begin
    status              = '0;
    status[0]           = busy;
    status[3:2]         = cur_idx_q;
    status[5:4]         = done_idx_q;
    status[16 +: CNT_W] = frame_cnt_q;
  end

  always_comb begin
    mem_rd_data = '0;
    case (rd_off)
      6'h00: mem_rd_data = {30'd0, irq_en_q, run_q};
      6'h01: mem_rd_data = status;
      6'h02: mem_rd_data = {29'd0, pend_q};
      6'h03: mem_rd_data = {29'd0, num_buf_q};
      6'h04, 6'h05, 6'h06, 6'h07: mem_rd_data = buf_addr_q[rd_off[1:0]];
      6'h08: mem_rd_data = xfer_len_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4lite_dma_frame_ctrl.sv
// Directed bench for axi4lite_dma_frame_ctrl: one instance with the default watchdog,
// one with a 16-cycle watchdog, both driven from the same stimulus.
module tb_axi4lite_dma_frame_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        mem_wr_valid = 1'b0;
  logic [31:0] mem_wr_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic [31:0] mem_rd_addr = '0;
  logic        dma_done = 1'b0;
  logic        dma_err = 1'b0;

  logic [31:0] a_rd_data, b_rd_data, a_dma_addr, b_dma_addr, a_dma_len, b_dma_len;
  logic        a_dma_start, b_dma_start, a_dma_abort, b_dma_abort, a_busy, b_busy, a_irq, b_irq;
  logic [1:0]  a_done_idx, b_done_idx;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4lite_dma_frame_ctrl dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(a_rd_data),
    .dma_start(a_dma_start), .dma_addr(a_dma_addr), .dma_len(a_dma_len),
    .dma_done(dma_done), .dma_err(dma_err), .dma_abort(a_dma_abort),
    .busy(a_busy), .done_buf_idx(a_done_idx), .irq(a_irq)
  );

  axi4lite_dma_frame_ctrl #(.TIMEOUT_CYCLES(24'd16)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(b_rd_data),
    .dma_start(b_dma_start), .dma_addr(b_dma_addr), .dma_len(b_dma_len),
    .dma_done(dma_done), .dma_err(dma_err), .dma_abort(b_dma_abort),
    .busy(b_busy), .done_buf_idx(b_done_idx), .irq(b_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_wr_valid = 1'b1;
    mem_wr_addr  = addr;
    mem_wr_data  = data;
    tick(1);
    mem_wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] a, output logic [31:0] b);
    mem_rd_addr = addr;
    #1;
    a = a_rd_data;
    b = b_rd_data;
  endtask

  task automatic pulse_done(input logic err);
    dma_done = 1'b1;
    dma_err  = err;
    tick(1);
    dma_done = 1'b0;
    dma_err  = 1'b0;
  endtask

  task automatic wait_start(input bit use_b, input string tag);
    int n = 0;
    while (((use_b ? b_dma_start : a_dma_start) !== 1'b1) && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, 32'(use_b ? b_dma_start : a_dma_start), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] rst_offs [10];
    logic [31:0] rst_exp  [10];
    logic [31:0] exp_addr [4];
    int starts;

    rst_offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h40};
    rst_exp  = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_addr = '{32'h1000, 32'h2000, 32'h3000, 32'h1000};

    // Reset state
    tick(3);
    aresetn = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      rd(rst_offs[i], ra, rb);
      check($sformatf("reset_rd_%02h", rst_offs[i]), ra, rst_exp[i]);
      tick(1);
    end
    check("reset_irq", 32'(a_irq), 32'd0);
    check("reset_busy", 32'(a_busy), 32'd0);
    check("reset_start", 32'(a_dma_start), 32'd0);

    // NUM_BUF clamping
    wr(32'h0C, 32'd0);
    rd(32'h0C, ra, rb);
    check("numbuf_zero_clamp", ra, 32'd1);
    wr(32'h0C, 32'd7);
    rd(32'h0C, ra, rb);
    check("numbuf_high_clamp", ra, 32'd4);

    // Watchdog on the 16-cycle instance
    wr(32'h0C, 32'd2);
    wr(32'h10, 32'hA000);
    wr(32'h14, 32'hB000);
    wr(32'h00, 32'h1);
    wait_start(1'b1, "to_start0");
    check("to_addr0", b_dma_addr, 32'hA000);
    tick(16);
    check("to_abort_early", 32'(b_dma_abort), 32'd0);
    tick(1);
    check("to_abort_pulse", 32'(b_dma_abort), 32'd1);
    tick(1);
    check("to_abort_end", 32'(b_dma_abort), 32'd0);
    wait_start(1'b1, "to_start1");
    check("to_addr1", b_dma_addr, 32'hB000);
    rd(32'h08, ra, rb);
    check("to_pend", rb, 32'h4);
    rd(32'h04, ra, rb);
    check("to_status", rb, 32'h0000_0005);

    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(1);

    // Four frames over three buffers
    wr(32'h0C, 32'd3);
    wr(32'h10, 32'h1000);
    wr(32'h14, 32'h2000);
    wr(32'h18, 32'h3000);
    wr(32'h20, 32'h1000);
    rd(32'h10C, ra, rb);
    check("alias_numbuf", ra, 32'd3);
    wr(32'h00, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_start(1'b0, $sformatf("frame%0d_start", i));
      check($sformatf("frame%0d_addr", i), a_dma_addr, exp_addr[i]);
      check($sformatf("frame%0d_len", i), a_dma_len, 32'h1000);
      tick(1);
      check($sformatf("frame%0d_start_1cyc", i), 32'(a_dma_start), 32'd0);
      tick(48);
      pulse_done(1'b0);
    end
    tick(3);
    rd(32'h04, ra, rb);
    check("status_after4", ra, 32'h0004_0005);
    check("done_idx_after4", 32'(a_done_idx), 32'd0);
    rd(32'h08, ra, rb);
    check("pend_after4", ra, 32'h1);
    check("irq_masked", 32'(a_irq), 32'd0);

    // Interrupt with DMA error on frame 5 (buffer 1)
    wr(32'h08, 32'h7);
    wr(32'h00, 32'h3);
    pulse_done(1'b1);
    check("irq_lat1", 32'(a_irq), 32'd0);
    tick(1);
    check("irq_lat2", 32'(a_irq), 32'd1);
    rd(32'h08, ra, rb);
    check("pend_err", ra, 32'h3);
    wr(32'h08, 32'h3);
    tick(1);
    check("irq_cleared", 32'(a_irq), 32'd0);
    check("frame6_addr", a_dma_addr, 32'h3000);

    // W1C coinciding with a hardware set: set wins
    mem_wr_valid = 1'b1;
    mem_wr_addr  = 32'h08;
    mem_wr_data  = 32'h3;
    pulse_done(1'b0);
    mem_wr_valid = 1'b0;
    rd(32'h08, ra, rb);
    check("w1c_vs_set", ra, 32'h1);

    // Frame 7 wraps to buffer 0; cnt_clr coinciding with completion clears
    wait_start(1'b0, "frame7_start");
    check("frame7_addr", a_dma_addr, 32'h1000);
    tick(5);
    mem_wr_valid = 1'b1;
    mem_wr_addr  = 32'h00;
    mem_wr_data  = 32'h7;
    pulse_done(1'b0);
    mem_wr_valid = 1'b0;
    rd(32'h04, ra, rb);
    check("cnt_clr_wins", ra, 32'h0000_0001);
    rd(32'h00, ra, rb);
    check("ctrl_readback", ra, 32'h3);

    // Clearing run mid-transfer lets the frame finish, then idles
    wait_start(1'b0, "frame8_start");
    check("frame8_addr", a_dma_addr, 32'h2000);
    wr(32'h00, 32'h2);
    tick(5);
    pulse_done(1'b0);
    starts = 0;
    repeat (20) begin
      tick(1);
      if (a_dma_start === 1'b1) starts++;
    end
    check("no_start_after_stop", 32'(starts), 32'd0);
    check("busy_after_stop", 32'(a_busy), 32'd0);
    rd(32'h04, ra, rb);
    check("status_stopped", ra, 32'h0001_0018);
    wr(32'h00, 32'h3);
    wait_start(1'b0, "frame9_start");
    check("frame9_addr", a_dma_addr, 32'h3000);

    // Asynchronous reset mid-WAIT
    tick(5);
    check("irq_before_reset", 32'(a_irq), 32'd1);
    aresetn = 1'b0;
    #1;
    check("rst_start", 32'(a_dma_start), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_addr", a_dma_addr, 32'h0);
    check("rst_len", a_dma_len, 32'h0);
    check("rst_done_idx", 32'(a_done_idx), 32'd0);
    check("rst_irq", 32'(a_irq), 32'd0);
    check("rst_abort", 32'(a_dma_abort), 32'd0);
    tick(2);
    aresetn = 1'b1;
    tick(2);
    pulse_done(1'b0);
    tick(3);
    rd(32'h04, ra, rb);
    check("late_done_status", ra, 32'h0);
    rd(32'h08, ra, rb);
    check("late_done_pend", ra, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_dma_frame_ctrl.md
Name: axi4lite_dma_frame_ctrl

Overview:
- Register bank and frame-buffer sequencer for the video DMA write path.
- Attaches to the memory-side interface of the AXI4-Lite adapter (write pulse plus combinational read port).
- Holds up to 4 frame buffer base addresses and issues one DMA transfer command per frame, rotating through the buffers.
- Reports the last completed buffer to downstream readers and raises an interrupt on frame completion, DMA error or timeout.

Parameters:
- TIMEOUT_CYCLES, 24'hFFFFFF: cycles allowed in WAIT before abort; 0 disables the watchdog.
- CNT_W, 16: frame counter width, range 1..16.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- mem_wr_valid  in  1  single-cycle register write strobe
- mem_wr_addr  in  32  write byte address; only [7:2] decoded
- mem_wr_data  in  32  write data
- mem_rd_addr  in  32  read byte address; only [7:2] decoded
- mem_rd_data  out  32  read data, combinational from mem_rd_addr
- dma_start  out  1  one-cycle transfer command
- dma_addr  out  32  buffer base address, held from START until the next START
- dma_len  out  32  transfer length in bytes, held from START until the next START
- dma_done  in  1  transfer complete pulse
- dma_err  in  1  error qualifier, sampled with dma_done
- dma_abort  out  1  one-cycle abort pulse on timeout
- busy  out  1  high in START, WAIT and NEXT
- done_buf_idx  out  2  index of the last completed buffer
- irq  out  1  registered level interrupt

Behaviour:
- Register map (byte offset):
  - 0x00 CTRL RW: [0] run, [1] irq_en. [2] cnt_clr is write-1, self-clearing and reads 0.
  - 0x04 STATUS RO: [0] busy, [3:2] cur_idx, [5:4] done_buf_idx, [16+CNT_W-1:16] frame_cnt.
  - 0x08 IRQ_PEND W1C: [0] frame_done, [1] dma_err, [2] timeout.
  - 0x0C NUM_BUF RW [2:0]: effective count is 1 when written 0, 4 when written >4; reads return the effective value.
  - 0x10/0x14/0x18/0x1C BUF_ADDR0..3 RW 32-bit.
  - 0x20 XFER_LEN RW 32-bit.
  - Unmapped offsets: reads return 0, writes are ignored; upper address bits alias.
- Register writes take effect the cycle after mem_wr_valid. Reads are purely combinational so data is valid during the adapter's registered read phase.
- Reset values: all registers 0 except NUM_BUF=1. Outputs dma_start, dma_abort, busy and irq are 0; dma_addr, dma_len and done_buf_idx are 0. FSM is in IDLE with cur_idx 0 and timer 0.
- FSM IDLE: when run=1, go to START next cycle.
- FSM START: assert dma_start for exactly one cycle. Latch dma_addr=BUF_ADDR[cur_idx] and dma_len=XFER_LEN. Clear the timer. Go to WAIT.
- FSM WAIT: timer increments each cycle.
  - On dma_done: done_buf_idx=cur_idx; frame_cnt+1 (wraps at 2^CNT_W); set pend[0]; also set pend[1] if dma_err. Go to NEXT.
  - Else, if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: pulse dma_abort, set pend[2], leave frame_cnt and done_buf_idx unchanged. Go to NEXT.
  - If dma_done coincides with expiry, done wins and no abort is issued.
- FSM NEXT: cur_idx = (cur_idx+1 >= effective NUM_BUF) ? 0 : cur_idx+1. Go to START if run=1, else IDLE.
- dma_done outside WAIT is ignored.
- Clearing run mid-transfer does not abort: the current transfer completes, then the FSM returns to IDLE. cur_idx is retained, and restart resumes from the next buffer.
- BUF_ADDR and XFER_LEN writes while busy take effect at the next START. A NUM_BUF reduction below cur_idx+1 is handled by the >= wrap in NEXT.
- cnt_clr coinciding with a frame_cnt increment: the clear wins and the result is 0.
- IRQ W1C clear coinciding with a hardware set of the same bit: the set wins.
- irq is registered: irq <= irq_en & |pend[2:0].

Test Plan:
- Reset, then read all offsets: NUM_BUF reads 1, all others 0, unmapped 0x40 reads 0; irq=0, busy=0.
- NUM_BUF=3, BUF_ADDR0..2=0x1000/0x2000/0x3000, XFER_LEN=0x1000, run=1, dma_done 50 cycles after each dma_start.
  - Required dma_addr sequence: 0x1000, 0x2000, 0x3000, 0x1000.
  - After 4 frames: STATUS frame_cnt=4, done_buf_idx=0.
- irq_en=1, one frame with dma_err=1:
  - pend=3'b011 and irq=1 two cycles after dma_done.
  - Write 0x3 to IRQ_PEND: irq=0. Write 0x3 in the same cycle as the next dma_done: pend[0] stays 1.
- TIMEOUT_CYCLES=16, withhold dma_done:
  - dma_abort pulses 16 cycles after WAIT entry, pend[2]=1, frame_cnt unchanged.
  - Sequencer advances to BUF_ADDR1.
- Clear run during WAIT: no new dma_start after the pending dma_done, busy falls to 0. Set run again: dma_start uses the next buffer index.
- Assert aresetn low during WAIT: all outputs return to reset values immediately. A late dma_done after reset release produces no count.
